sram_controller: RTL and testbench
==================================

# sram_controller

Sequences 32-bit data-memory accesses from the MEM stage onto an external 16-bit asynchronous SRAM, as two 16-bit half-word transfers followed by a settle period. Sits between Mem_Stage and the SRAM pins. Drops `ready` while an access is in flight so the pipeline freezes until the access retires.

## Interface
Parameters:
- `WAIT_CYCLES`, default 4: settle cycles after the high half-word transfer, range 0–15.
- `DATA_BASE`, default 1024: byte address mapped to SRAM word 0.

Ports (clock and reset first):
- `clk` input, 1: sole clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `wr_en` input, 1: store request from the MEM stage, held until `ready`.
- `rd_en` input, 1: load request from the MEM stage, held until `ready`.
- `address` input, 32: byte address (ALU result).
- `write_data` input, 32: store value.
- `read_data` output, 32: registered load result.
- `ready` output, 1: low freezes the pipeline.
- `SRAM_DQ` inout, 16: SRAM data bus.
- `SRAM_ADDR` output, 18: SRAM half-word address.
- `SRAM_WE_N` output, 1: SRAM write strobe, active-low.

## Operation
- States: IDLE, LOW, HIGH, HOLD, DONE.
- IDLE:
  - `rd_en|wr_en` → LOW; latch the operation (write wins if both are high), the address and `write_data`.
  - Otherwise stay in IDLE.
- LOW → HIGH.
- HIGH → HOLD if `WAIT_CYCLES>0`, else → DONE.
- HOLD:
  - The counter loads `WAIT_CYCLES-1` on entry.
  - Exit to DONE when the counter reaches 0.
- DONE → IDLE unconditionally.
- Address mapping: `eff = address - DATA_BASE` (32-bit, wraps). Word index `w = eff[18:2]`.
  - LOW drives `SRAM_ADDR = {w,1'b0}`.
  - HIGH drives `SRAM_ADDR = {w,1'b1}`.
  - `eff[1:0]` and `eff[31:19]` are ignored.
- Write:
  - LOW: `SRAM_DQ = wdata[15:0]`, `SRAM_WE_N = 0`.
  - HIGH: `SRAM_DQ = wdata[31:16]`, `SRAM_WE_N = 0`.
- Read:
  - `SRAM_WE_N = 1` throughout.
  - `SRAM_DQ` sampled at the end of LOW into `read_data[15:0]`, and at the end of HIGH into `read_data[31:16]`.
- `SRAM_DQ` is high-Z in every state except LOW and HIGH of a write.
- `SRAM_ADDR` holds its last value outside LOW and HIGH.
- `ready = ~(rd_en|wr_en) | (state==DONE)` (combinational).
- `read_data` holds its value until the next read overwrites it. Writes never alter it.
- Request deasserted mid-access: the access completes and the FSM reaches IDLE. There is no abort.

## Timing
- Reset values: state IDLE, `SRAM_WE_N = 1`, `SRAM_ADDR = 0`, `SRAM_DQ` high-Z, `read_data = 0`, counter 0. `ready = 1` whenever no request is present.
- Access latency, counting the IDLE sampling cycle as cycle 0:
  - LOW in cycle 1, HIGH in cycle 2, HOLD in cycles 3..2+W.
  - DONE in cycle 3+W, with `ready = 1`.
  - `ready` is low for exactly 3+W cycles (7 at default).
- The pipeline advances on the edge that ends DONE. The next request is sampled in the following IDLE cycle, so back-to-back accesses cost 4+W cycles each.
- Read data: the low half is valid from cycle 2, the full 32 bits from cycle 3 onward.
- `rst` mid-access: state goes to IDLE at the next edge, and `SRAM_WE_N` rises and `SRAM_DQ` releases in that same cycle. A partially written word is left as-is.

## Structure
- Shared package `sram_pkg`: state enum (IDLE/LOW/HIGH/HOLD/DONE), `SRAM_AW=18`, `SRAM_DW=16`, default `DATA_BASE`.
- Single module. The settle counter is inline (4-bit down-counter); no sub-module is warranted.
- The tri-state is implemented as one continuous assign gated by `(state==LOW||state==HIGH) && op_write`.

## Test plan
- Idle: `rd_en = wr_en = 0` for 10 cycles → `ready = 1` throughout, `SRAM_WE_N = 1`, `SRAM_DQ` high-Z.
- Write: `wr_en`, `address = 1024`, `write_data = 0xDEADBEEF` → `SRAM_ADDR` 0 then 1, DQ `0xBEEF` then `0xDEAD`, `WE_N` low for 2 cycles, `ready` low for 7 cycles then high for 1.
- Read-back: `rd_en`, `address = 1024`, SRAM model preloaded as above → `read_data = 0xDEADBEEF` by DONE, `WE_N` never low.
- Mapping: `address = 1024+12` → `SRAM_ADDR` 6 then 7. `address = 1024+14` → same as 12 (byte offset ignored).
- Simultaneous `rd_en = wr_en = 1`, `write_data = 0x12345678` → write performed, `read_data` unchanged.
- Reset mid-write: assert `rst` in HIGH → next cycle IDLE, `WE_N = 1`, DQ high-Z, `read_data = 0`. With `WAIT_CYCLES = 0`, `ready` is low for exactly 3 cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the external 16-bit SRAM data-memory path.
//   state_t           - access sequencer states
//   SRAM_AW / SRAM_DW - SRAM half-word address width and data width
//   DEFAULT_DATA_BASE - byte address that maps to SRAM word 0
package sram_pkg;

    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;
    localparam logic [31:0] DEFAULT_DATA_BASE = 32'd1024;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/sram_controller.sv
// sram_controller: turns one 32-bit MEM-stage load/store into two 16-bit
// transfers on an asynchronous SRAM (low half-word, then high half-word),
// followed by WAIT_CYCLES settle cycles. The pipeline is frozen (ready low)
// from the cycle a request is seen until the access reaches DONE.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   wr_en       - store request, held until ready
//   rd_en       - load request, held until ready
//   address     - byte address (ALU result)
//   write_data  - store value
//   read_data   - registered load result, kept until the next load
//   ready       - low while an access is in flight
//   SRAM_DQ     - bidirectional SRAM data bus
//   SRAM_ADDR   - SRAM half-word address (registered)
//   SRAM_WE_N   - SRAM write strobe, active low (registered)
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N
);

    // Settle counter start value; only used when WAIT_CYCLES > 0.
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    logic        op_write;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [3:0]  cnt;
    logic [16:0] word_idx;

    // 32-bit wrapping offset from the data base; byte offset and bits above
    // the SRAM range are dropped by taking bits [18:2].
    assign word_idx = 17'((address - DATA_BASE) >> 2);

    assign ready = ~(rd_en | wr_en) | (state == DONE);

    assign SRAM_DQ = ((state == LOW || state == HIGH) && op_write)
                     ? ((state == LOW) ? wdata[15:0] : wdata[31:16])
                     : 'z;

    // Address and strobe are set up on the edge entering each transfer state,
    // so they are stable for the whole of LOW/HIGH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_write  <= 1'b0;
            word      <= '0;
            wdata     <= '0;
            cnt       <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en | wr_en) begin
                        state     <= LOW;
                        op_write  <= wr_en;
                        word      <= word_idx;
                        wdata     <= write_data;
                        SRAM_ADDR <= {word_idx, 1'b0};
                        SRAM_WE_N <= ~wr_en;
                    end
                end
                LOW: begin
                    state     <= HIGH;
                    SRAM_ADDR <= {word, 1'b1};
                    if (!op_write) begin
                        read_data[15:0] <= SRAM_DQ;
                    end
                end
                HIGH: begin
                    SRAM_WE_N <= 1'b1;
                    if (!op_write) begin
                        read_data[31:16] <= SRAM_DQ;
                    end
                    if (WAIT_CYCLES > 0) begin
                        state <= HOLD;
                        cnt   <= CNT_INIT;
                    end else begin
                        state <= DONE;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed scoreboard bench for sram_controller with a
// behavioural asynchronous SRAM on the data bus. A second instance with
// WAIT_CYCLES = 0 checks the shortest access.
`timescale 1ns/1ps
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] dq;
    logic [17:0] sram_addr;
    logic        we_n;

    logic        z_wr_en, z_rd_en;
    logic [31:0] z_read_data;
    logic        z_ready;
    wire  [15:0] z_dq;
    logic [17:0] z_sram_addr;
    logic        z_we_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(4), .DATA_BASE(32'd1024)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .SRAM_DQ(dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n)
    );

    sram_controller #(.WAIT_CYCLES(0), .DATA_BASE(32'd1024)) dut_zero (
        .clk(clk), .rst(rst), .wr_en(z_wr_en), .rd_en(z_rd_en),
        .address(address), .write_data(write_data), .read_data(z_read_data),
        .ready(z_ready), .SRAM_DQ(z_dq), .SRAM_ADDR(z_sram_addr), .SRAM_WE_N(z_we_n)
    );

    // SRAM model: output enabled whenever not writing; writes on each edge
    // while WE_N is low.
    logic [15:0] mem [0:63];
    logic        mem_init;
    assign dq = we_n ? mem[sram_addr[5:0]] : 'z;

    always @(posedge clk) begin
        if (mem_init) mem[0] <= 16'h1357;
        else if (!we_n) mem[sram_addr[5:0]] <= dq;
    end

    typedef struct {
        logic        we_n;
        logic [17:0] addr;
        logic [15:0] dq;
    } beat_t;

    typedef struct {
        int          low_cycles;
        logic [31:0] rdata;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts ready-low cycles of the current access; cycles 2 and 3
    // are the LOW and HIGH transfers, ready rising ends the access.
    int k = 0;
    always @(negedge clk) begin
        beat_t b;
        done_t d;
        if (rst) begin
            k = 0;
        end else if (rd_en | wr_en) begin
            if (!ready) begin
                k++;
                if (k == 2 || k == 3) begin
                    if (beat_q.size() == 0) begin
                        check("beat_unexpected", 32'(k), 32'd0);
                    end else begin
                        b = beat_q.pop_front();
                        check("beat_we_n", 32'(we_n), 32'(b.we_n));
                        check("beat_addr", 32'(sram_addr), 32'(b.addr));
                        if (!b.we_n) check("beat_dq", 32'(dq), 32'(b.dq));
                    end
                end
            end else begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'(k), 32'd0);
                end else begin
                    d = done_q.pop_front();
                    check("ready_low_cycles", 32'(k), 32'(d.low_cycles));
                    check("read_data", read_data, d.rdata);
                end
                k = 0;
            end
        end
    end

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [17:0] exp_lo,
                          input logic [31:0] exp_rd);
        bit seen = 0;
        beat_q.push_back('{we_n: ~w, addr: exp_lo,         dq: d[15:0]});
        beat_q.push_back('{we_n: ~w, addr: exp_lo + 18'd1, dq: d[31:16]});
        done_q.push_back('{low_cycles: 7, rdata: exp_rd});
        @(posedge clk); #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin seen = 1; break; end
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
    endtask

    initial begin
        rst = 1; mem_init = 1;
        wr_en = 0; rd_en = 0; z_wr_en = 0; z_rd_en = 0;
        address = '0; write_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0; mem_init = 0;

        // Reset state and idle behaviour
        @(negedge clk);
        check("reset_read_data", read_data, 32'd0);
        check("reset_addr", 32'(sram_addr), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_we_n", 32'(we_n), 32'd1);
            check("idle_dq_released", 32'(dq), 32'h1357);
        end

        access(1, 0, 32'd1024,      32'hDEADBEEF, 18'd0, 32'h0);
        access(0, 1, 32'd1024,      32'h0,        18'd0, 32'hDEADBEEF);
        access(1, 0, 32'd1024 + 12, 32'h11112222, 18'd6, 32'hDEADBEEF);
        access(1, 0, 32'd1024 + 14, 32'h33334444, 18'd6, 32'hDEADBEEF);
        access(0, 1, 32'd1024 + 12, 32'h0,        18'd6, 32'h33334444);
        // Both requests: write wins, read_data untouched
        access(1, 1, 32'd1024 + 16, 32'h12345678, 18'd8, 32'h33334444);

        @(negedge clk);
        check("idle_after_access", 32'(ready), 32'd1);

        // Reset asserted during HIGH of a write
        beat_q.push_back('{we_n: 1'b0, addr: 18'd10, dq: 16'hF00D});
        beat_q.push_back('{we_n: 1'b0, addr: 18'd11, dq: 16'hCAFE});
        @(posedge clk); #1;
        wr_en = 1; address = 32'd1024 + 20; write_data = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1 rst = 1; wr_en = 0;
        @(negedge clk);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_dq_released", 32'(dq), 32'h0000BEEF);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        @(posedge clk); #1 rst = 0;

        // WAIT_CYCLES = 0 instance: shortest access
        begin
            int lows = 0;
            int wes = 0;
            bit seen = 0;
            @(posedge clk); #1;
            z_wr_en = 1; address = 32'd1024 + 4; write_data = 32'hAAAA5555;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!z_we_n) wes++;
                if (z_ready) begin seen = 1; break; end
                lows++;
            end
            check("zero_wait_done_seen", 32'(seen), 32'd1);
            check("zero_wait_ready_low", 32'(lows), 32'd3);
            check("zero_wait_we_low", 32'(wes), 32'd2);
            @(posedge clk); #1 z_wr_en = 0;
        end

        repeat (3) @(negedge clk);
        check("beat_queue_empty", 32'(beat_q.size()), 32'd0);
        check("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
